// File: rtl/npu_pwr_pkg.sv
// Shared types and default timing constants for the NPU power-domain gating controller.
package npu_pwr_pkg;

   localparam int STATE_W        = 3;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_ISO_DLY    = 2;
   localparam int DEF_PWR_UP_DLY = 16;
   localparam int DEF_CG_IDLE    = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN     = 3'd0,
      ST_CGATE   = 3'd1,
      ST_ISO     = 3'd2,
      ST_SAVE    = 3'd3,
      ST_OFF     = 3'd4,
      ST_PUP     = 3'd5,
      ST_RESTORE = 3'd6,
      ST_UNISO   = 3'd7
   } pwrState_e;

   typedef struct packed {
      logic clkEn;
      logic pwrEn;
      logic isoEn;
      logic retSave;
      logic retRestore;
   } pwrOut_t;

   // Gating-net levels for the state being entered; PD_ACK is history-dependent and lives in the top.
   function automatic pwrOut_t stateOutputs(input pwrState_e s);
      pwrOut_t o;
      o = '{clkEn: 1'b0, pwrEn: 1'b1, isoEn: 1'b1, retSave: 1'b0, retRestore: 1'b0};
      case (s)
         ST_RUN:     begin o.clkEn = 1'b1; o.isoEn = 1'b0; end
         ST_CGATE:   o.isoEn = 1'b0;
         ST_SAVE:    o.retSave = 1'b1;
         ST_OFF:     o.pwrEn = 1'b0;
         ST_RESTORE: o.retRestore = 1'b1;
         ST_UNISO:   o.isoEn = 1'b0;
         default:    ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/npu_pwr_settle_cnt.sv
// Saturating settle counter shared by the isolation hold and the rail power-up wait.
import npu_pwr_pkg::*;

module npu_pwr_settle_cnt #(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_term,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   // Holds at the terminal value so a late PWR_GOOD still sees o_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != i_term)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_done = (r_cnt == i_term);

endmodule

// File: rtl/npu_pwr_gate_ctrl.sv
// Power-gating sequencer for one NPU domain: clock gate, isolate, save, rail off/on, restore.
import npu_pwr_pkg::*;

module npu_pwr_gate_ctrl #(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int ISO_DLY    = DEF_ISO_DLY,
   parameter int PWR_UP_DLY = DEF_PWR_UP_DLY,
   parameter int CG_IDLE    = DEF_CG_IDLE
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               PD_REQ,
   input  logic               IDLE,
   input  logic               PWR_GOOD,
   output logic               PD_ACK,
   output logic               CLK_EN,
   output logic               PWR_EN,
   output logic               ISO_EN,
   output logic               RET_SAVE,
   output logic               RET_RESTORE,
   output logic [STATE_W-1:0] STATE
);

   localparam logic [CNT_W-1:0] ISO_TERM  = CNT_W'(ISO_DLY - 1);
   localparam logic [CNT_W-1:0] PUP_TERM  = CNT_W'(PWR_UP_DLY - 1);
   localparam logic [CNT_W-1:0] IDLE_TERM = (CG_IDLE > 0) ? CNT_W'(CG_IDLE - 1) : '0;
   localparam logic [CNT_W-1:0] IDLE_MAX  = '1;

   pwrState_e        r_state;
   pwrState_e        w_nextState;
   pwrOut_t          w_nextOut;
   logic [CNT_W-1:0] r_idleCnt;
   logic [CNT_W-1:0] w_settleCnt;
   logic [CNT_W-1:0] w_settleTerm;
   logic             w_settleDone;
   logic             w_idleHit;
   logic             r_retValid;
   logic             r_pdAck;
   logic             r_clkEn;
   logic             r_pwrEn;
   logic             r_isoEn;
   logic             r_retSave;
   logic             r_retRestore;

   assign w_settleTerm = (r_state == ST_ISO) ? ISO_TERM : PUP_TERM;
   assign w_idleHit    = (CG_IDLE != 0) && IDLE && (r_idleCnt >= IDLE_TERM);

   npu_pwr_settle_cnt #(.CNT_W(CNT_W)) u_settle (
      .clk    (CLK),
      .rst    (RST),
      .i_clr  (w_nextState != r_state),
      .i_en   ((r_state == ST_ISO) || (r_state == ST_PUP)),
      .i_term (w_settleTerm),
      .o_cnt  (w_settleCnt),
      .o_done (w_settleDone)
   );

   // PD_REQ outranks idle gating; a request dropped early never aborts the power-down.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_RUN: begin
            if (PD_REQ)         w_nextState = ST_ISO;
            else if (w_idleHit) w_nextState = ST_CGATE;
         end
         ST_CGATE: begin
            if (PD_REQ)     w_nextState = ST_ISO;
            else if (!IDLE) w_nextState = ST_RUN;
         end
         ST_ISO:     if (w_settleDone) w_nextState = ST_SAVE;
         ST_SAVE:    w_nextState = ST_OFF;
         ST_OFF:     if (!PD_REQ) w_nextState = ST_PUP;
         ST_PUP: begin
            if (w_settleDone && PWR_GOOD)
               w_nextState = r_retValid ? ST_RESTORE : ST_UNISO;
         end
         ST_RESTORE: w_nextState = ST_UNISO;
         ST_UNISO:   w_nextState = ST_RUN;
         default:    w_nextState = ST_PUP;
      endcase
      w_nextOut = stateOutputs(w_nextState);
   end

   // Outputs are registered with the state so gating nets never see combinational glitches.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_PUP;
         r_clkEn      <= 1'b0;
         r_pwrEn      <= 1'b1;
         r_isoEn      <= 1'b1;
         r_retSave    <= 1'b0;
         r_retRestore <= 1'b0;
         r_pdAck      <= 1'b0;
         r_retValid   <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_clkEn      <= w_nextOut.clkEn;
         r_pwrEn      <= w_nextOut.pwrEn;
         r_isoEn      <= w_nextOut.isoEn;
         r_retSave    <= w_nextOut.retSave;
         r_retRestore <= w_nextOut.retRestore;
         if (w_nextState == ST_OFF)      r_pdAck <= 1'b1;
         else if (w_nextState == ST_RUN) r_pdAck <= 1'b0;
         if (w_nextState == ST_SAVE)         r_retValid <= 1'b1;
         else if (w_nextState == ST_RESTORE) r_retValid <= 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_idleCnt <= '0;
      end else if (!IDLE || (r_state != ST_RUN) || (w_nextState != ST_RUN)) begin
         r_idleCnt <= '0;
      end else if (r_idleCnt != IDLE_MAX) begin
         r_idleCnt <= r_idleCnt + 1'b1;
      end
   end

   assign PD_ACK      = r_pdAck;
   assign CLK_EN      = r_clkEn;
   assign PWR_EN      = r_pwrEn;
   assign ISO_EN      = r_isoEn;
   assign RET_SAVE    = r_retSave;
   assign RET_RESTORE = r_retRestore;
   assign STATE       = r_state;

endmodule

// File: tb/tb_npu_pwr_gate_ctrl.sv
// Directed self-checking bench for npu_pwr_gate_ctrl with default parameters.
module tb_npu_pwr_gate_ctrl;

   localparam logic [2:0] S_RUN = 3'd0, S_CGATE = 3'd1, S_ISO = 3'd2, S_SAVE = 3'd3;
   localparam logic [2:0] S_OFF = 3'd4, S_PUP = 3'd5, S_RESTORE = 3'd6, S_UNISO = 3'd7;

   // Output vector order: {PD_ACK, CLK_EN, PWR_EN, ISO_EN, RET_SAVE, RET_RESTORE}
   localparam logic [5:0] O_PUP0    = 6'b001100;
   localparam logic [5:0] O_UNISO0  = 6'b001000;
   localparam logic [5:0] O_RUN     = 6'b011000;
   localparam logic [5:0] O_CGATE   = 6'b001000;
   localparam logic [5:0] O_ISO     = 6'b001100;
   localparam logic [5:0] O_SAVE    = 6'b001110;
   localparam logic [5:0] O_OFF     = 6'b100100;
   localparam logic [5:0] O_PUP1    = 6'b101100;
   localparam logic [5:0] O_RESTORE = 6'b101101;
   localparam logic [5:0] O_UNISO1  = 6'b101000;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       PD_REQ = 1'b0;
   logic       IDLE = 1'b0;
   logic       PWR_GOOD = 1'b1;
   logic       PD_ACK, CLK_EN, PWR_EN, ISO_EN, RET_SAVE, RET_RESTORE;
   logic [2:0] STATE;
   logic [5:0] outs;

   int nCompared = 0;
   int nMismatched = 0;

   assign outs = {PD_ACK, CLK_EN, PWR_EN, ISO_EN, RET_SAVE, RET_RESTORE};

   always #5 CLK = ~CLK;

   npu_pwr_gate_ctrl dut (
      .CLK         (CLK),
      .RST         (RST),
      .PD_REQ      (PD_REQ),
      .IDLE        (IDLE),
      .PWR_GOOD    (PWR_GOOD),
      .PD_ACK      (PD_ACK),
      .CLK_EN      (CLK_EN),
      .PWR_EN      (PWR_EN),
      .ISO_EN      (ISO_EN),
      .RET_SAVE    (RET_SAVE),
      .RET_RESTORE (RET_RESTORE),
      .STATE       (STATE)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic checkState(input string tag, input logic [2:0] expState, input logic [5:0] expOuts);
      checkOutput({tag, "_state"}, {29'd0, STATE}, {29'd0, expState});
      checkOutput({tag, "_outs"}, {26'd0, outs}, {26'd0, expOuts});
   endtask

   task automatic applyStimulus(input logic req, input logic idle, input logic pg);
      PD_REQ   = req;
      IDLE     = idle;
      PWR_GOOD = pg;
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Wakeup path used after reset: 16 PUP cycles, no restore, one UNISO, then RUN.
   task automatic wakeNoRetention(input string tag, input logic [5:0] pupOuts, input logic [5:0] unisoOuts);
      for (int i = 0; i < 16; i++) begin
         checkState({tag, "_pup"}, S_PUP, pupOuts);
         tick();
      end
      checkState({tag, "_uniso"}, S_UNISO, unisoOuts);
      tick();
      checkState({tag, "_run"}, S_RUN, O_RUN);
   endtask

   task automatic powerDownToOff(input string tag);
      tick(); checkState({tag, "_iso1"}, S_ISO, O_ISO);
      tick(); checkState({tag, "_iso2"}, S_ISO, O_ISO);
      tick(); checkState({tag, "_save"}, S_SAVE, O_SAVE);
      tick(); checkState({tag, "_off"}, S_OFF, O_OFF);
   endtask

   always @(negedge CLK) begin
      if (!RST) checkOutput("clkEnSafe", {31'd0, CLK_EN & (ISO_EN | ~PWR_EN)}, 32'd0);
   end

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge CLK);
      checkState("reset", S_PUP, O_PUP0);
      RST = 1'b0;
      wakeNoRetention("boot", O_PUP0, O_UNISO0);

      // Eight idle cycles gate the clock; releasing IDLE ungates on the next edge.
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         tick(); checkState("idle8_run", S_RUN, O_RUN);
      end
      tick(); checkState("idle8_cgate", S_CGATE, O_CGATE);
      tick(); checkState("cgate_hold", S_CGATE, O_CGATE);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(); checkState("cgate_wake", S_RUN, O_RUN);

      for (int r = 0; r < 2; r++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         for (int i = 0; i < 7; i++) begin
            tick(); checkState("idle7_run", S_RUN, O_RUN);
         end
         applyStimulus(1'b0, 1'b0, 1'b1);
         tick(); checkState("idle7_drop", S_RUN, O_RUN);
      end

      // Full power cycle with retention.
      applyStimulus(1'b1, 1'b0, 1'b1);
      powerDownToOff("pc");
      tick(); checkState("pc_offHold", S_OFF, O_OFF);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 16; i++) begin
         checkState("pc_pup", S_PUP, O_PUP1);
         tick();
      end
      checkState("pc_restore", S_RESTORE, O_RESTORE);
      tick(); checkState("pc_uniso", S_UNISO, O_UNISO1);
      tick(); checkState("pc_run", S_RUN, O_RUN);

      // Rail slow to settle: PUP holds until PWR_GOOD, then restores immediately.
      applyStimulus(1'b1, 1'b0, 1'b1);
      powerDownToOff("pg");
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         tick(); checkState("pg_wait", S_PUP, O_PUP1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(); checkState("pg_restore", S_RESTORE, O_RESTORE);
      tick(); checkState("pg_uniso", S_UNISO, O_UNISO1);
      tick(); checkState("pg_run", S_RUN, O_RUN);

      // Asynchronous reset while OFF discards retention.
      applyStimulus(1'b1, 1'b0, 1'b1);
      powerDownToOff("rst");
      #2 RST = 1'b1;
      #1 checkState("rst_async", S_PUP, O_PUP0);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b1);
      RST = 1'b0;
      wakeNoRetention("rstWake", O_PUP0, O_UNISO0);

      // PD_REQ beats IDLE, and a one-cycle request still completes one OFF cycle.
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick(); checkState("pulse_iso1", S_ISO, O_ISO);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(); checkState("pulse_iso2", S_ISO, O_ISO);
      tick(); checkState("pulse_save", S_SAVE, O_SAVE);
      tick(); checkState("pulse_off", S_OFF, O_OFF);
      tick();
      for (int i = 0; i < 16; i++) begin
         checkState("pulse_pup", S_PUP, O_PUP1);
         tick();
      end
      checkState("pulse_restore", S_RESTORE, O_RESTORE);
      tick(); checkState("pulse_uniso", S_UNISO, O_UNISO1);
      tick(); checkState("pulse_run", S_RUN, O_RUN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
